// File: rtl/ide_pio_strobe_seq_if.sv
// -----------------------------------------------------------------------------
// ide_pio_strobe_seq_if
//
// Bundles the signals between the Amiga bus decode / IDE drive port and the
// PIO strobe sequencer.
//
//   nas          68000 address strobe, active low      (decode  -> sequencer)
//   r_w          1 = read, 0 = write                   (decode  -> sequencer)
//   ide_sel      decoded IDE task-file access          (decode  -> sequencer)
//   iordy        drive IORDY, asynchronous, 1 = ready  (drive   -> sequencer)
//   nior/niow    IDE read/write strobes, active low    (sequencer -> drive)
//   dtack        request to the open-drain DTACK driver
//   dd_oe        drive CPU write data onto DD
//   d_oe         drive latched read data onto D
//   rd_latch_en  one-cycle capture pulse for the read latch
//   busy         sequencer is not idle
//   timeout_evt  one-cycle pulse when an IORDY wait is force-completed
//
// Modports:
//   master  the bus/drive side that feeds the sequencer
//   slave   the sequencer itself
// -----------------------------------------------------------------------------
interface ide_pio_strobe_seq_if;
  logic nas;
  logic r_w;
  logic ide_sel;
  logic iordy;
  logic nior;
  logic niow;
  logic dtack;
  logic dd_oe;
  logic d_oe;
  logic rd_latch_en;
  logic busy;
  logic timeout_evt;

  modport master (
    output nas,
    output r_w,
    output ide_sel,
    output iordy,
    input  nior,
    input  niow,
    input  dtack,
    input  dd_oe,
    input  d_oe,
    input  rd_latch_en,
    input  busy,
    input  timeout_evt
  );

  modport slave (
    input  nas,
    input  r_w,
    input  ide_sel,
    input  iordy,
    output nior,
    output niow,
    output dtack,
    output dd_oe,
    output d_oe,
    output rd_latch_en,
    output busy,
    output timeout_evt
  );
endinterface

// File: rtl/ide_pio_strobe_seq.sv
// -----------------------------------------------------------------------------
// ide_pio_strobe_seq
//
// Turns a decoded IDE register access into IDE PIO timing, all counted in
// cpuclk7 cycles:
//   SETUP    address/CS setup before the strobe           (T_SETUP cycles)
//   ACTIVE   DIOR/DIOW low for the minimum strobe width   (T_ACTIVE cycles)
//   WAIT     strobe held low while IORDY is low            (<= IORDY_TIMEOUT)
//   HOLD     strobe released, DTACK given until AS rises
//   RECOVER  strobe-high recovery before the next access   (T_RECOVER cycles)
// It also produces DTACK and the data-buffer enables.
//
// Ports:
//   cpuclk7  the only clock; everything on its rising edge
//   nreset   synchronous active-low reset
//   bus      ide_pio_strobe_seq_if.slave (see the interface for members)
//
// nior/niow are registered and are derived from the state being entered, so
// they change in the same edge as the state register. The remaining outputs
// are decoded from registered state only (no input-to-output paths).
// -----------------------------------------------------------------------------
module ide_pio_strobe_seq #(
  parameter int T_SETUP       = 1,
  parameter int T_ACTIVE      = 3,
  parameter int T_RECOVER     = 2,
  parameter int IORDY_TIMEOUT = 32,
  parameter int CNT_W         = 6
) (
  input  logic                cpuclk7,
  input  logic                nreset,
  ide_pio_strobe_seq_if.slave bus
);

  localparam int SYNC_STAGES = 2;

  localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(T_SETUP);
  localparam logic [CNT_W-1:0] LD_ACTIVE  = CNT_W'(T_ACTIVE);
  localparam logic [CNT_W-1:0] LD_RECOVER = CNT_W'(T_RECOVER);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(IORDY_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_WAIT,
    ST_HOLD,
    ST_RECOVER
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic nas_q;
  logic ide_sel_q;
  logic r_w_q;

  // ide_sel and r_w are registered alongside nas so the three are coherent
  // when the IDLE state looks at them.
  always_ff @(posedge cpuclk7) begin
    if (!nreset) begin
      nas_q     <= 1'b1;
      ide_sel_q <= 1'b0;
      r_w_q     <= 1'b1;
    end else begin
      nas_q     <= bus.nas;
      ide_sel_q <= bus.ide_sel;
      r_w_q     <= bus.r_w;
    end
  end

  // IORDY comes straight from the drive cable: two-flop synchroniser.
  logic [SYNC_STAGES-1:0] iordy_sync_reg;
  logic [SYNC_STAGES-1:0] iordy_sync_next;
  logic                   iordy_s;

  assign iordy_sync_next[0] = bus.iordy;

  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_iordy_shift
      assign iordy_sync_next[gi] = iordy_sync_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge cpuclk7) begin
    if (!nreset) begin
      iordy_sync_reg <= '1;
    end else begin
      iordy_sync_reg <= iordy_sync_next;
    end
  end

  assign iordy_s = iordy_sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             dir_reg;
  logic             dir_next;
  logic             nior_reg;
  logic             nior_next;
  logic             niow_reg;
  logic             niow_next;

  logic             cnt_last;
  logic             strobe_next;

  logic             dtack_c;
  logic             dd_oe_c;
  logic             d_oe_c;
  logic             rd_latch_c;
  logic             timeout_c;
  logic             busy_c;

  // A phase loaded with N is in its last cycle when the counter reads 1.
  assign cnt_last = (cnt_reg == CNT_ONE);

  always_ff @(posedge cpuclk7) begin
    if (!nreset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
      nior_reg  <= 1'b1;
      niow_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      nior_reg  <= nior_next;
      niow_reg  <= niow_next;
    end
  end

  // Next state, counter and the cycle-level outputs.
  // In SETUP/ACTIVE/WAIT an address-strobe release (abort) is checked first
  // so it always wins over a completion in the same cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    dtack_c    = 1'b0;
    dd_oe_c    = 1'b0;
    d_oe_c     = 1'b0;
    rd_latch_c = 1'b0;
    timeout_c  = 1'b0;
    busy_c     = (state_reg != ST_IDLE);

    case (state_reg)
      ST_IDLE: begin
        if (!nas_q && ide_sel_q) begin
          dir_next   = r_w_q;
          cnt_next   = LD_SETUP;
          state_next = ST_SETUP;
        end
      end

      ST_SETUP: begin
        dd_oe_c = !dir_reg;
        if (nas_q) begin
          cnt_next   = LD_RECOVER;
          state_next = ST_RECOVER;
        end else if (cnt_last) begin
          cnt_next   = LD_ACTIVE;
          state_next = ST_ACTIVE;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      ST_ACTIVE: begin
        dd_oe_c = !dir_reg;
        if (nas_q) begin
          cnt_next   = LD_RECOVER;
          state_next = ST_RECOVER;
        end else if (cnt_last) begin
          if (iordy_s) begin
            rd_latch_c = dir_reg;
            state_next = ST_HOLD;
          end else begin
            cnt_next   = LD_TIMEOUT;
            state_next = ST_WAIT;
          end
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      ST_WAIT: begin
        dd_oe_c = !dir_reg;
        if (nas_q) begin
          cnt_next   = LD_RECOVER;
          state_next = ST_RECOVER;
        end else if (iordy_s) begin
          // Ready on the final timeout cycle still counts as a normal finish.
          rd_latch_c = dir_reg;
          state_next = ST_HOLD;
        end else if (cnt_last) begin
          rd_latch_c = dir_reg;
          timeout_c  = 1'b1;
          state_next = ST_HOLD;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      ST_HOLD: begin
        // dd_oe stays on here so write data is held past the strobe edge.
        dd_oe_c = !dir_reg;
        dtack_c = !nas_q;
        d_oe_c  = dir_reg & !nas_q;
        if (nas_q) begin
          cnt_next   = LD_RECOVER;
          state_next = ST_RECOVER;
        end
      end

      ST_RECOVER: begin
        if (cnt_last) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Strobes follow the state being entered, so they are low exactly while
  // the state register holds ACTIVE or WAIT, and only one of them at a time.
  always_comb begin
    strobe_next = (state_next == ST_ACTIVE) || (state_next == ST_WAIT);
    nior_next   = !(strobe_next && dir_next);
    niow_next   = !(strobe_next && !dir_next);
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.nior        = nior_reg;
  assign bus.niow        = niow_reg;
  assign bus.dtack       = dtack_c;
  assign bus.dd_oe       = dd_oe_c;
  assign bus.d_oe        = d_oe_c;
  assign bus.rd_latch_en = rd_latch_c;
  assign bus.busy        = busy_c;
  assign bus.timeout_evt = timeout_c;

endmodule

// File: tb/tb_ide_pio_strobe_seq.sv
// -----------------------------------------------------------------------------
// tb_ide_pio_strobe_seq
//
// Drives IDE accesses (directed cases, then random ones) through the master
// side of the interface. For every access the expected observable behaviour
// is worked out from the timing rules (phase lengths, IORDY sync delay,
// timeout cap, abort rules) and pushed to a queue; an independent monitor
// measures each busy period on the outputs and compares it to the queue head.
// -----------------------------------------------------------------------------
module tb_ide_pio_strobe_seq;

  localparam int TS    = 1;
  localparam int TA    = 3;
  localparam int TR    = 2;
  localparam int TO    = 32;
  // Edge (counted from the negedge where the access starts) at which the
  // last ACTIVE cycle decides between HOLD and WAIT.
  localparam int A_END = 1 + TS + TA;

  logic cpuclk7;
  logic nreset;

  ide_pio_strobe_seq_if bus ();

  ide_pio_strobe_seq #(
    .T_SETUP      (TS),
    .T_ACTIVE     (TA),
    .T_RECOVER    (TR),
    .IORDY_TIMEOUT(TO),
    .CNT_W        (6)
  ) dut (
    .cpuclk7(cpuclk7),
    .nreset (nreset),
    .bus    (bus)
  );

  initial cpuclk7 = 1'b0;
  always #5 cpuclk7 = ~cpuclk7;

  typedef struct {
    int dir;
    int low;
    int dtack_cyc;
    int dtack_ofs;
    int rd_pulses;
    int to_pulses;
    int d_oe_cyc;
    int dd_oe_cyc;
    int busy_cyc;
    int setup_lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   idle_bad;
  bit   mon_en;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One access. Called at the negedge right after the previous nas release
  // (or with the sequencer idle). gap = negedges from that release to the
  // new nas fall. r = negedge (from access start) at which iordy returns
  // high (0: never low). abort: release nas before completion.
  task automatic run_txn(input int dir, input int r, input bit abort,
                         input int hsel, input int gap);
    exp_t e;
    int   e_rdy, e_done, a, wait_n;
    bit   timed_out;

    repeat (gap - 1) begin
      bus.nas = 1'b1; bus.iordy = 1'b1;
      @(negedge cpuclk7);
    end
    // An access raised during recovery is only taken once recovery is over.
    wait_n = ((gap > TR + 1) ? gap : TR + 1) - gap;
    repeat (wait_n) begin
      bus.nas = 1'b0; bus.r_w = dir[0]; bus.ide_sel = 1'b1; bus.iordy = 1'b1;
      @(negedge cpuclk7);
    end

    // iordy driven at negedge k is seen by the sequencer at edge k+2.
    e_rdy     = (r == 0) ? 0 : r + 2;
    e_done    = (e_rdy > A_END) ? e_rdy : A_END;
    timed_out = (e_rdy > A_END + TO);
    if (e_done > A_END + TO) e_done = A_END + TO;
    if (abort) a = 1 + (hsel % (e_done - 1));
    else       a = e_done + 1 + hsel;

    e.dir       = dir;
    e.low       = abort ? ((a > TS) ? a - TS : 0) : e_done - 1 - TS;
    e.dtack_cyc = abort ? 0 : a - e_done;
    e.dtack_ofs = abort ? -1 : e_done - 1;
    e.rd_pulses = (!abort && dir == 1) ? 1 : 0;
    e.to_pulses = (!abort && timed_out) ? 1 : 0;
    e.d_oe_cyc  = (!abort && dir == 1) ? a - e_done : 0;
    e.dd_oe_cyc = (dir == 1) ? 0 : a;
    e.busy_cyc  = a + TR;
    e.setup_lat = (e.low > 0) ? TS : -1;
    exp_q.push_back(e);

    for (int k = 0; k <= a; k++) begin
      bus.nas     = (k >= a);
      bus.r_w     = dir[0];
      bus.ide_sel = 1'b1;
      bus.iordy   = (k >= r) || (k >= a);
      @(negedge cpuclk7);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin : monitor
    int   cyc, nior_lo, niow_lo, dt, dt_ofs, rd, tmo, doe, ddoe;
    int   first_low, both_lo, both_oe, txn_no;
    bit   in_txn;
    exp_t e;
    in_txn = 1'b0;
    txn_no = 0;
    cyc = 0; nior_lo = 0; niow_lo = 0; dt = 0; dt_ofs = -1; rd = 0; tmo = 0;
    doe = 0; ddoe = 0; first_low = -1; both_lo = 0; both_oe = 0;
    forever begin
      @(negedge cpuclk7);
      if (mon_en) begin
        if (bus.busy) begin
          if (!in_txn) begin
            in_txn = 1'b1;
            cyc = 0; nior_lo = 0; niow_lo = 0; dt = 0; dt_ofs = -1; rd = 0;
            tmo = 0; doe = 0; ddoe = 0; first_low = -1; both_lo = 0; both_oe = 0;
          end
          if (!bus.nior) nior_lo++;
          if (!bus.niow) niow_lo++;
          if ((!bus.nior || !bus.niow) && first_low < 0) first_low = cyc;
          if (!bus.nior && !bus.niow) both_lo++;
          if (bus.d_oe && bus.dd_oe) both_oe++;
          if (bus.dtack) begin
            dt++;
            if (dt_ofs < 0) dt_ofs = cyc;
          end
          if (bus.rd_latch_en) rd++;
          if (bus.timeout_evt) tmo++;
          if (bus.d_oe) doe++;
          if (bus.dd_oe) ddoe++;
          cyc++;
        end else begin
          if (bus.dtack || bus.d_oe || bus.dd_oe || bus.rd_latch_en ||
              bus.timeout_evt || !bus.nior || !bus.niow) idle_bad++;
          if (in_txn) begin
            in_txn = 1'b0;
            txn_no++;
            if (exp_q.size() == 0) begin
              check("unexpected_access", 1, 0);
            end else begin
              e = exp_q.pop_front();
              $display("txn %0d: dir=%0d strobe_low=%0d dtack=%0d busy=%0d timeout=%0d",
                       txn_no, e.dir, (e.dir == 1) ? nior_lo : niow_lo, dt, cyc, tmo);
              check("sel_strobe_low", (e.dir == 1) ? nior_lo : niow_lo, e.low);
              check("other_strobe_low", (e.dir == 1) ? niow_lo : nior_lo, 0);
              check("setup_latency", first_low, e.setup_lat);
              check("dtack_cycles", dt, e.dtack_cyc);
              check("dtack_offset", dt_ofs, e.dtack_ofs);
              check("rd_latch_pulses", rd, e.rd_pulses);
              check("timeout_pulses", tmo, e.to_pulses);
              check("d_oe_cycles", doe, e.d_oe_cyc);
              check("dd_oe_cycles", ddoe, e.dd_oe_cyc);
              check("busy_cycles", cyc, e.busy_cyc);
              check("strobes_overlap", both_lo, 0);
              check("oe_overlap", both_oe, 0);
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    int  cnt, dir, r, hs, g, sel;
    bit  ab, found;
    n_checks = 0;
    n_fail   = 0;
    idle_bad = 0;
    mon_en   = 1'b0;
    nreset   = 1'b0;
    bus.nas = 1'b1; bus.r_w = 1'b1; bus.ide_sel = 1'b0; bus.iordy = 1'b1;

    repeat (3) @(negedge cpuclk7);
    check("rst_nior", bus.nior, 1);
    check("rst_niow", bus.niow, 1);
    check("rst_dtack", bus.dtack, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_dd_oe", bus.dd_oe, 0);
    check("rst_d_oe", bus.d_oe, 0);
    check("rst_rd_latch", bus.rd_latch_en, 0);
    check("rst_timeout", bus.timeout_evt, 0);
    nreset = 1'b1;
    repeat (3) @(negedge cpuclk7);
    mon_en = 1'b1;

    // nas without ide_sel must be ignored.
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      bus.nas = 1'b0; bus.ide_sel = 1'b0;
      @(negedge cpuclk7);
      if (bus.busy) cnt++;
    end
    bus.nas = 1'b1;
    repeat (4) @(negedge cpuclk7);
    check("no_sel_busy", cnt, 0);

    // Directed: dir, r, abort, hsel, gap
    run_txn(1, 0, 1'b0, 2, 4);     // read, IORDY ready
    run_txn(0, 0, 1'b0, 1, 4);     // write, IORDY ready
    run_txn(1, 8, 1'b0, 1, 4);     // IORDY stretch
    run_txn(0, 200, 1'b0, 1, 4);   // IORDY stuck low -> timeout
    run_txn(1, 35, 1'b0, 0, 4);    // ready exactly on the timeout cycle
    run_txn(0, 36, 1'b0, 0, 4);    // ready one cycle too late
    run_txn(1, 0, 1'b0, 0, 4);
    run_txn(1, 0, 1'b0, 0, 1);     // back-to-back, nas low during recovery
    run_txn(0, 0, 1'b0, 2, 2);
    run_txn(1, 0, 1'b0, 1, TR + 1);
    run_txn(1, 0, 1'b1, 0, 4);     // abort in SETUP
    run_txn(0, 0, 1'b1, 2, 4);     // abort in ACTIVE
    run_txn(1, 200, 1'b1, 20, 4);  // abort in WAIT

    for (int t = 0; t < 40; t++) begin
      dir = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      r   = (sel < 5) ? 0 : (sel < 8) ? int'($urandom_range(1, 40)) : 200;
      ab  = ($urandom_range(0, 4) == 0);
      hs  = ab ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 4));
      g   = int'($urandom_range(1, 6));
      run_txn(dir, r, ab, hs, g);
    end

    bus.nas = 1'b1; bus.iordy = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge cpuclk7);
    check("scoreboard_drained", exp_q.size(), 0);
    repeat (4) @(negedge cpuclk7);
    check("idle_outputs_quiet", idle_bad, 0);

    // Reset while the strobe is low.
    mon_en = 1'b0;
    bus.nas = 1'b0; bus.r_w = 1'b1; bus.ide_sel = 1'b1; bus.iordy = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge cpuclk7);
      if (!bus.nior) found = 1'b1;
    end
    check("mid_rst_strobe_reached", found, 1);
    nreset  = 1'b0;
    bus.nas = 1'b1;
    @(negedge cpuclk7);
    check("mid_rst_nior", bus.nior, 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_dtack", bus.dtack, 0);
    nreset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge cpuclk7);
      if (bus.dtack || bus.busy || !bus.nior) cnt++;
    end
    check("post_rst_quiet", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
